scr1_imem_match_mon: RTL
========================

# scr1_imem_match_mon

Parametrised, synthesizable instruction-fetch match monitor attached to the IMEM response path beside the AHB/AXI IMEM bridge. It compares every valid fetched word against NUM_CH programmable mask/value channels. For each channel it keeps a saturating hit counter. For every matching fetch it pushes {channel id, PC} into a capture FIFO that a debug/trace consumer drains through a valid/ready handshake. It generalises single-pattern fetch-and-print checking (for example, a SLT detect: opcode 0110011, funct3 010) into a multi-channel, counted, buffered hardware block.

## Interface
Parameters:
- NUM_CH, 4: number of match channels, 1..16.
- FIFO_DEPTH, 8: capture FIFO entries; must be a power of two and at least 2.
- CNT_W, 16: hit counter width, 1..32.
- CH_W is derived as max(1, $clog2(NUM_CH)). LVL_W is derived as $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  core clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- imem_resp  in  2  IMEM response code; 2'b01 means a valid read. All other codes are ignored.
- imem_rdata  in  32  fetched instruction word.
- curr_pc  in  32  PC associated with the current response.
- cfg_en  in  NUM_CH  per-channel enable.
- cfg_mask  in  NUM_CH*32  channel i uses bits [32i+31:32i].
- cfg_value  in  NUM_CH*32  channel i uses bits [32i+31:32i].
- cnt_clr  in  1  synchronous clear of all hit counters and of evt_ovf.
- hit_cnt  out  NUM_CH*CNT_W  per-channel saturating hit counters.
- evt_vld  out  1  FIFO head valid.
- evt_rdy  in  1  consumer accepts the head.
- evt_ch  out  CH_W  channel id of the head entry.
- evt_pc  out  32  PC of the head entry.
- evt_level  out  LVL_W  FIFO occupancy.
- evt_ovf  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Channel i matches when all of these hold: cfg_en[i]=1, imem_resp==2'b01, and (imem_rdata & mask_i) == (value_i & mask_i).
- Mask all zeros with the channel enabled: the channel matches every valid fetch.
- Stage S1 registers the match vector m[NUM_CH-1:0] and curr_pc. Configuration is sampled in the response cycle, so a configuration change affects only fetches that occur after it.
- Stage S2 acts on the registered S1 values:
  - Counters: every set bit m[i] increments hit_cnt[i]. A counter that is all-ones holds its value (saturates).
  - FIFO push: one push when m is non-zero. The entry holds ch = lowest set index of m, and pc = the S1 pc.
- FIFO behaviour:
  - Pop occurs when evt_vld and evt_rdy are both 1.
  - Push while full and no pop in the same cycle: the entry is dropped and evt_ovf is set.
  - Push while full with a pop in the same cycle: the push is accepted and the level is unchanged.
  - Push and pop while empty: the new entry appears next cycle; it is not bypassed in the same cycle.
  - Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty are decided from evt_level.
- cnt_clr:
  - When a counter clear and an S2 increment occur in the same cycle, the clear wins and the counter becomes 0.
  - When evt_ovf would be set in the same cycle as cnt_clr, the set wins and evt_ovf stays 1.
  - cnt_clr does not affect the FIFO.
- Reset values:
  - S1 and S2 valid cleared, all hit_cnt = 0, pointers = 0.
  - evt_vld = 0, evt_level = 0, evt_ovf = 0, evt_ch = 0, evt_pc = 0.
  - Reset asserted mid-operation discards S1/S2 contents and FIFO contents.

## Timing
- Response in cycle T:
  - m is registered at the end of T.
  - The counter update and FIFO push occur at the end of T+1.
  - The hit_cnt change is visible in T+2.
  - evt_vld rises in T+2 if the FIFO was empty; evt_level increments in T+2.
- Back-to-back valid responses sustain one push per cycle. There are no bubbles and no stalls toward the IMEM path; the block never back-pressures the core.
- evt_ch and evt_pc are registered FIFO-head outputs and remain stable while evt_vld=1 and evt_rdy=0.
- After a pop, the next entry, if any, is presented in the following cycle.

## Test plan
- SLT detect:
  - Setup: ch0 mask=0x0000707F, value=0x00002033. Fetch 0x0020A1B3 (slt x3,x1,x2) at pc=0x200.
  - Required: hit_cnt[0]=1 in T+2, evt_vld=1, evt_ch=0, evt_pc=0x200.
  - Then fetch add 0x002081B3: no event is produced.
- Multi-channel overlap:
  - Setup: ch1 matches opcode 0x33 only, ch2 matches the same SLT pattern as ch0. Single SLT fetch.
  - Required: hit_cnt[0]=hit_cnt[1]=hit_cnt[2]=1, exactly one FIFO entry with evt_ch=0.
- Overflow:
  - Stimulus: evt_rdy=0, 10 consecutive matching fetches at pcs 0x0,0x4,...,0x24, FIFO_DEPTH=8.
  - Required: evt_level=8, evt_ovf=1. Draining yields pcs 0x0..0x1C in order.
  - Then pulse cnt_clr: evt_ovf=0 and all counters=0.
- Full with simultaneous push/pop: with the FIFO full and evt_rdy=1, a matching fetch keeps evt_level=8 and evt_ovf stays 0.
- Saturation / clear race:
  - Setup: CNT_W=2, 5 hits on ch0. Required: hit_cnt[0]=3.
  - Then cnt_clr coinciding with an S2 increment: required hit_cnt[0]=0.
- Reset / ignore:
  - imem_resp=2'b10 with matching rdata: no count and no event.
  - rst asserted with 3 entries queued and a match in S1: next cycle evt_vld=0, evt_level=0, all counters=0.

Source files
------------

// File: rtl/scr1_imem_match_mon.sv
// Instruction-fetch match monitor: compares each valid IMEM response against
// NUM_CH mask/value channels, counts hits per channel and queues {ch, pc} events.
module scr1_imem_match_mon #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              imem_resp,
    input  logic [31:0]             imem_rdata,
    input  logic [31:0]             curr_pc,
    input  logic [NUM_CH-1:0]       cfg_en,
    input  logic [NUM_CH*32-1:0]    cfg_mask,
    input  logic [NUM_CH*32-1:0]    cfg_value,
    input  logic                    cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] hit_cnt,
    output logic                    evt_vld,
    input  logic                    evt_rdy,
    output logic [CH_W-1:0]         evt_ch,
    output logic [31:0]             evt_pc,
    output logic [LVL_W-1:0]        evt_level,
    output logic                    evt_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0] m_raw;
    logic [NUM_CH-1:0] s1_m;
    logic [31:0]       s1_pc;

    always_comb begin
        m_raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_raw[i] = cfg_en[i] && (imem_resp == 2'b01) &&
                       (((imem_rdata ^ cfg_value[32*i +: 32]) & cfg_mask[32*i +: 32]) == 32'h0);
        end
    end

    // A non-zero s1_m doubles as the stage-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_m  <= '0;
            s1_pc <= '0;
        end else begin
            s1_m  <= m_raw;
            s1_pc <= curr_pc;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (rst || cnt_clr) begin
                    cnt_q <= '0;
                end else if (s1_m[g] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    logic [CH_W-1:0] push_ch;

    always_comb begin
        push_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (s1_m[i]) push_ch = CH_W'(i);
        end
    end

    logic [CH_W-1:0]  mem_ch [FIFO_DEPTH];
    logic [31:0]      mem_pc [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [LVL_W-1:0] level_nxt;
    logic [CH_W-1:0]  head_ch_nxt;
    logic [31:0]      head_pc_nxt;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_acc;
    logic             ovf_set;

    assign push      = |s1_m;
    assign pop       = evt_vld && evt_rdy;
    assign full      = (evt_level == LVL_W'(FIFO_DEPTH));
    assign push_acc  = push && (!full || pop);
    assign ovf_set   = push && full && !pop;
    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

    always_comb begin
        level_nxt = evt_level;
        if (push_acc && !pop) level_nxt = evt_level + LVL_W'(1);
        else if (!push_acc && pop) level_nxt = evt_level - LVL_W'(1);
    end

    // Head registers track what mem[rd_ptr] will hold after this edge, so
    // evt_ch/evt_pc come straight from flops and read zero when empty.
    always_comb begin
        head_ch_nxt = evt_ch;
        head_pc_nxt = evt_pc;
        if (level_nxt == '0) begin
            head_ch_nxt = '0;
            head_pc_nxt = '0;
        end else if ((evt_level == '0) || ((evt_level == LVL_W'(1)) && pop)) begin
            head_ch_nxt = push_ch;
            head_pc_nxt = s1_pc;
        end else if (pop) begin
            head_ch_nxt = mem_ch[rd_ptr_p1];
            head_pc_nxt = mem_pc[rd_ptr_p1];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_ch[wr_ptr] <= push_ch;
            mem_pc[wr_ptr] <= s1_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_level <= '0;
            evt_vld   <= 1'b0;
            evt_ch    <= '0;
            evt_pc    <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr_p1;
            evt_level <= level_nxt;
            evt_vld   <= (level_nxt != '0);
            evt_ch    <= head_ch_nxt;
            evt_pc    <= head_pc_nxt;
            if (ovf_set) evt_ovf <= 1'b1;
            else if (cnt_clr) evt_ovf <= 1'b0;
        end
    end

endmodule
